// File: rtl/eth_tx_fcs_ctrl.sv
// Ethernet TX sequencer: passes payload, zero-pads to MIN_FRAME and appends the reflected CRC-32 FCS.
// Output is registered with one cycle of latency; m_ready stalls hold the output and drop s_ready. IFG_CYCLES idle cycles separate frames.
module eth_tx_fcs_ctrl #(
  parameter int MIN_FRAME  = 60,
  parameter int IFG_CYCLES = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = $clog2(MIN_FRAME + 2);
  localparam int IW = $clog2(IFG_CYCLES + 2);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_FRAME);
  localparam logic [IW-1:0] IFG_C = IW'(IFG_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'b0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   crc_q, crc_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [1:0]    fcs_idx_q, fcs_idx_d;
  logic [IW-1:0] ifg_cnt_q, ifg_cnt_d;
  logic          m_valid_q, m_valid_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_last_q, m_last_d;
  logic          frame_done_q, frame_done_d;

  logic          out_free;
  logic          in_hs;
  logic          last_hs;
  logic [CW-1:0] cnt_inc;
  logic [IW-1:0] ifg_cnt_inc;
  logic [31:0]   fcs_word;
  logic [7:0]    fcs_byte;

  assign out_free    = !m_valid_q || m_ready;
  assign s_ready     = ((state_q == ST_IDLE) || (state_q == ST_DATA)) && out_free;
  assign in_hs       = s_valid && s_ready;
  assign last_hs     = m_valid_q && m_ready && m_last_q;
  // Saturating: long frames keep counting at MIN_FRAME so the pad decision stays valid.
  assign cnt_inc     = (byte_cnt_q < MIN_C) ? byte_cnt_q + CW'(1) : byte_cnt_q;
  assign ifg_cnt_inc = ifg_cnt_q + IW'(1);
  assign fcs_word    = ~crc_q;
  assign fcs_byte    = fcs_word[{fcs_idx_q, 3'b000} +: 8];

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    byte_cnt_d   = byte_cnt_q;
    fcs_idx_d    = fcs_idx_q;
    ifg_cnt_d    = ifg_cnt_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    frame_done_d = last_hs;

    if (out_free) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (in_hs) begin
          crc_d      = crc_byte(32'hFFFFFFFF, s_data);
          byte_cnt_d = CW'(1);
          m_valid_d  = 1'b1;
          m_data_d   = s_data;
          if (s_last) state_d = (CW'(1) < MIN_C) ? ST_PAD : ST_FCS;
          else        state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (in_hs) begin
          crc_d      = crc_byte(crc_q, s_data);
          byte_cnt_d = cnt_inc;
          m_valid_d  = 1'b1;
          m_data_d   = s_data;
          if (s_last) state_d = (cnt_inc < MIN_C) ? ST_PAD : ST_FCS;
        end
      end
      ST_PAD: begin
        if (out_free) begin
          crc_d      = crc_byte(crc_q, 8'h00);
          byte_cnt_d = cnt_inc;
          m_valid_d  = 1'b1;
          m_data_d   = 8'h00;
          if (cnt_inc >= MIN_C) state_d = ST_FCS;
        end
      end
      ST_FCS: begin
        // fcs_idx wraps back to 0 after the fourth byte, ready for the next frame.
        if (out_free) begin
          m_valid_d = 1'b1;
          m_data_d  = fcs_byte;
          fcs_idx_d = fcs_idx_q + 2'd1;
          if (fcs_idx_q == 2'd3) begin
            m_last_d = 1'b1;
            state_d  = ST_IFG;
          end
        end
      end
      ST_IFG: begin
        // Nothing is loaded in IFG, so m_valid_q high means the m_last byte is still pending.
        if (m_valid_q) begin
          if (last_hs) begin
            ifg_cnt_d = '0;
            if (IFG_CYCLES == 0) state_d = ST_IDLE;
          end
        end else if (ifg_cnt_inc >= IFG_C) begin
          state_d = ST_IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      crc_q        <= 32'hFFFFFFFF;
      byte_cnt_q   <= '0;
      fcs_idx_q    <= '0;
      ifg_cnt_q    <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= 8'h00;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      byte_cnt_q   <= byte_cnt_d;
      fcs_idx_q    <= fcs_idx_d;
      ifg_cnt_q    <= ifg_cnt_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
